// File: rtl/wsc_planner_if.sv
// Handshake and status bundle between the crossing planner and its driver/river model.
interface wsc_planner_if;
  logic       start;
  logic       variant;
  logic       ext_valid;
  logic [2:0] ext_move;
  logic       mv_valid;
  logic       mv_ready;
  logic [2:0] move;
  logic [3:0] state;
  logic [2:0] step;
  logic       busy;
  logic       done;
  logic       rej;
  logic       solved;

  modport master (
    output start, variant, ext_valid, ext_move, mv_ready,
    input  mv_valid, move, state, step, busy, done, rej, solved
  );

  modport slave (
    input  start, variant, ext_valid, ext_move, mv_ready,
    output mv_valid, move, state, step, busy, done, rej, solved
  );
endinterface

// File: rtl/wsc_planner.sv
// Wolf/sheep/cabbage river-crossing planner: runs a fixed 7-move plan or vets manual moves.
// Bank state is {t,w,s,c}, move code is {w,s,c}; a crossing toggles t plus every moved item.
module wsc_planner (
  input  logic        clk,
  input  logic        rst,
  wsc_planner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e       fsm_q;
  logic [3:0] state_q;
  logic [2:0] step_q;
  logic       var_q;
  logic       rej_q;

  function automatic logic unsafe(input logic [3:0] b);
    return ((b[2] == b[1]) && (b[2] != b[3])) || ((b[1] == b[0]) && (b[1] != b[3]));
  endfunction

  // Variant 1 swaps the wolf and cab crossings (entries 2 and 4).
  function automatic logic [2:0] plan_mv(input logic v, input logic [2:0] i);
    case (i)
      3'd0:    return 3'b010;
      3'd1:    return 3'b000;
      3'd2:    return v ? 3'b001 : 3'b100;
      3'd3:    return 3'b010;
      3'd4:    return v ? 3'b100 : 3'b001;
      3'd5:    return 3'b000;
      default: return 3'b010;
    endcase
  endfunction

  logic [2:0] move_cur;
  logic [3:0] man_d;
  logic       man_code_ok, man_side_ok, man_legal;

  always_comb begin
    move_cur    = plan_mv(var_q, step_q);
    man_d       = state_q ^ {1'b1, bus.ext_move};
    man_code_ok = $onehot0(bus.ext_move);
    // Every moved item must sit on the farmer's bank before the crossing.
    man_side_ok = (bus.ext_move & (state_q[2:0] ^ {3{state_q[3]}})) == 3'b000;
    man_legal   = man_code_ok && man_side_ok && !unsafe(man_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= 4'b0000;
      step_q  <= 3'd0;
      var_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (bus.start) begin
            fsm_q   <= RUN;
            state_q <= 4'b0000;
            step_q  <= 3'd0;
            var_q   <= bus.variant;
          end else if (bus.ext_valid) begin
            if (man_legal) state_q <= man_d;
            else           rej_q   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.mv_ready) begin
            state_q <= state_q ^ {1'b1, move_cur};
            step_q  <= step_q + 3'd1;
            if (step_q == 3'd6) fsm_q <= DONE;
          end
        end
        DONE:    fsm_q <= IDLE;
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.mv_valid = (fsm_q == RUN);
  assign bus.busy     = (fsm_q == RUN);
  assign bus.done     = (fsm_q == DONE);
  assign bus.rej      = rej_q;
  assign bus.move     = move_cur;
  assign bus.state    = state_q;
  assign bus.step     = step_q;
  assign bus.solved   = (state_q == 4'b1111);

  a_plan_safe: assert property (@(posedge clk) disable iff (rst)
    (fsm_q == RUN) |-> !unsafe(state_q));
  c_solved_v0: cover property (@(posedge clk) disable iff (rst)
    (fsm_q == DONE) && bus.solved && !var_q);
  c_solved_v1: cover property (@(posedge clk) disable iff (rst)
    (fsm_q == DONE) && bus.solved && var_q);
endmodule
